ysyx_24100006_axi_arbiter: RTL and testbench
============================================

Name: ysyx_24100006_axi_arbiter

Overview:
- Two-master, one-slave AXI arbiter that shares the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Grants one whole transaction at a time.
- Holds the grant from the address handshake until the final data beat (rlast) or the write response, then returns to arbitration.
- Sits between the IFU/LSU AXI masters and the SRAM/crossbar slave.

Parameters:
ADDR_W, 32, address width of all channels
DATA_W, 32, data width; wstrb width is DATA_W/8

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ifu_araddr/ifu_arlen/ifu_arsize  input  ADDR_W/8/3  IFU read address, burst length, beat size
ifu_arvalid / ifu_arready  input / output  1 / 1  IFU AR handshake
ifu_rdata/ifu_rresp/ifu_rlast  output  DATA_W/2/1  IFU read data beat
ifu_rvalid / ifu_rready  output / input  1 / 1  IFU R handshake
lsu_araddr/lsu_arlen/lsu_arsize  input  ADDR_W/8/3  LSU read address
lsu_arvalid / lsu_arready  input / output  1 / 1  LSU AR handshake
lsu_rdata/lsu_rresp/lsu_rlast  output  DATA_W/2/1  LSU read data
lsu_rvalid / lsu_rready  output / input  1 / 1  LSU R handshake
lsu_awaddr/lsu_awlen/lsu_awsize  input  ADDR_W/8/3  LSU write address
lsu_awvalid / lsu_awready  input / output  1 / 1  LSU AW handshake
lsu_wdata/lsu_wstrb/lsu_wlast  input  DATA_W/DATA_W/8/1  LSU write data
lsu_wvalid / lsu_wready  input / output  1 / 1  LSU W handshake
lsu_bresp / lsu_bvalid / lsu_bready  output / output / input  2/1/1  LSU write response
mem_ar*, mem_r*, mem_aw*, mem_w*, mem_b*  mirrored directions  same widths  slave-side channels (araddr, arlen, arsize, arvalid, arready, rdata, rresp, rlast, rvalid, rready, awaddr, awlen, awsize, awvalid, awready, wdata, wstrb, wlast, wvalid, wready, bresp, bvalid, bready)

Behaviour:

States:
- IDLE, IFU_RD, LSU_RD, LSU_WR.
- The state register is the only grant storage. Channel muxing is combinational from the state.

Reset:
- reset low forces state=IDLE asynchronously, including mid-burst.
- While in IDLE, every valid/ready output on both sides is 0 and all data/addr outputs are 0.
- Outstanding transactions are abandoned; the slave must be reset together with the arbiter.

IDLE arbitration:
- Sampled each clk edge.
- LSU request = lsu_arvalid | lsu_awvalid; IFU request = ifu_arvalid.
- Winner's state is entered next cycle, giving 1 cycle of arbitration latency. No handshake completes in IDLE.
- Within the LSU, arvalid takes precedence over awvalid; LSU_WR is entered only if lsu_arvalid=0.
- Default policy is fixed priority: LSU beats IFU.

IFU_RD:
- mem_ar* = ifu_ar*; ifu_arready = mem_arready.
- ifu_r* = mem_r*; mem_rready = ifu_rready.
- All LSU readies and valids are 0.
- Exit to IDLE on the cycle of mem_rvalid & mem_rready & mem_rlast.

LSU_RD:
- Same as IFU_RD with the LSU connected. Exit on the rlast handshake.

LSU_WR:
- AW and W are forwarded independently, so awready and wready may arrive in any order or the same cycle.
- mem_b* goes to lsu_b*.
- Exit on mem_bvalid & mem_bready.
- mem_ar*/mem_r* handshakes are held 0.

Responses:
- rresp/bresp are passed through unmodified. Error responses do not alter sequencing.

Non-granted masters:
- They see ready=0 and rvalid/bvalid=0.
- They must hold valid and payload stable until granted (AXI rule); the arbiter does not latch requests.

Bursts:
- arlen=N produces N+1 beats. The grant is held for all of them regardless of competing requests.

Back-to-back:
- After an exit, IDLE always spends at least 1 cycle before the next grant.

Optional Feature:
- Macro: YSYX_24100006_ARB_RR_EN
- Defined:
  - Round-robin arbitration. A 1-bit last_grant register records the last granted master (reset value = IFU).
  - On simultaneous IFU and LSU requests in IDLE, the master that was not last granted wins.
  - A single requester always wins.
- Undefined: fixed LSU-over-IFU priority; no last_grant register exists.

Test Plan:
1. IFU alone: ifu_arvalid=1, araddr=0x80000000, arlen=0; mem_arready after 2 cycles; mem_rdata=0x00000413, rlast=1 -> mem_arvalid rises 1 cycle after request; ifu_rvalid/ifu_rdata=0x00000413 in the same cycle as mem_rvalid; state returns to IDLE; lsu_* readies stay 0 throughout.
2. IFU and LSU AR in the same cycle (LSU araddr 0x80001000) -> fixed: LSU served first, IFU second. With RR: first tie after reset goes to LSU; on the next tie, IFU wins.
3. LSU write: awaddr 0x80001004, wdata 0xDEADBEEF, wstrb 4'b0100; mem_wready 1 cycle before mem_awready; bresp=2'b00 -> both handshakes complete, lsu_bvalid=1 with bresp 00, then IDLE. Repeat with bresp=2'b10 -> lsu_bresp=2'b10 passed through.
4. IFU burst arlen=3 with an LSU request arriving after beat 1 -> 4 IFU beats delivered, LSU granted only in the cycle after IDLE following rlast, and lsu_arready=0 until then.
5. Reset pulled low during LSU_RD after the AR handshake -> in the same cycle, all mem_*valid/ready and lsu_*valid outputs go to 0. After reset release, a pending ifu_arvalid is granted 1 cycle later.

Source files
------------

// File: rtl/ysyx_24100006_axi_arbiter.sv
// ysyx_24100006_axi_arbiter
//
// Two-master, one-slave AXI arbiter. The instruction fetch unit (IFU, read
// only) and the load/store unit (LSU, read/write) share one memory port.
// One whole transaction is granted at a time. The grant is held from the
// address handshake to the final read beat (rlast) or the write response,
// and then the arbiter returns to IDLE for at least one cycle.
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   ifu_ar*, ifu_r*     IFU read address / read data channels
//   lsu_ar*, lsu_r*     LSU read address / read data channels
//   lsu_aw*, lsu_w*,
//   lsu_b*              LSU write address / write data / write response
//   mem_*               slave-side channels (same widths, directions mirrored)
//
// Build option:
//   YSYX_24100006_ARB_RR_EN  defined   -> round-robin between IFU and LSU
//                            undefined -> fixed priority, LSU over IFU
//
// The state register is the only grant storage; every channel mux is
// combinational from it. Requests are never latched: a master that is not
// granted must hold its valid and payload stable.

module ysyx_24100006_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    // IFU read channels
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rlast,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,

    // LSU read channels
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rlast,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,

    // LSU write channels
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [7:0]          lsu_awlen,
    input  logic [2:0]          lsu_awsize,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,

    // Slave-side channels
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic [7:0]          mem_arlen,
    output logic [2:0]          mem_arsize,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic                mem_rlast,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic [7:0]          mem_awlen,
    output logic [2:0]          mem_awsize,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wlast,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic [1:0]          mem_bresp,
    input  logic                mem_bvalid,
    output logic                mem_bready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic ifu_req;
    logic lsu_req;
    logic lsu_wins;
    logic r_done;
    logic b_done;

`ifdef YSYX_24100006_ARB_RR_EN
    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    grant_e last_grant_q, last_grant_d;
`endif

    // ------------------------------------------------------------------
    // Arbitration decision (only consulted in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        ifu_req = ifu_arvalid;
        lsu_req = lsu_arvalid | lsu_awvalid;
`ifdef YSYX_24100006_ARB_RR_EN
        // On a tie the master that was not granted last time wins.
        lsu_wins = lsu_req & (~ifu_req | (last_grant_q == GNT_IFU));
`else
        lsu_wins = lsu_req;
`endif
    end

    // Completion events, using the muxed ready the slave actually sees.
    assign r_done = mem_rvalid & mem_rready & mem_rlast;
    assign b_done = mem_bvalid & mem_bready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a
        // path that skips the assignment would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lsu_wins) begin
                    // Within the LSU a read takes precedence over a write.
                    state_d = lsu_arvalid ? LSU_RD : LSU_WR;
                end else if (ifu_req) begin
                    state_d = IFU_RD;
                end
            end
            IFU_RD,
            LSU_RD:  if (r_done) state_d = IDLE;
            LSU_WR:  if (b_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef YSYX_24100006_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && state_d != IDLE) begin
            last_grant_d = (state_d == IFU_RD) ? GNT_IFU : GNT_LSU;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef YSYX_24100006_ARB_RR_EN
    // Reset to IFU so the first tie after reset goes to the LSU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GNT_IFU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Channel muxing, purely from the registered grant. IDLE leaves every
    // output at zero on both sides.
    // ------------------------------------------------------------------
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rlast   = 1'b0;
        ifu_rvalid  = 1'b0;

        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rlast   = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;

        mem_araddr  = '0;
        mem_arlen   = '0;
        mem_arsize  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = '0;
        mem_awlen   = '0;
        mem_awsize  = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wlast   = 1'b0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;

        case (state_q)
            IFU_RD: begin
                mem_araddr  = ifu_araddr;
                mem_arlen   = ifu_arlen;
                mem_arsize  = ifu_arsize;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
                ifu_rdata   = mem_rdata;
                ifu_rresp   = mem_rresp;
                ifu_rlast   = mem_rlast;
                ifu_rvalid  = mem_rvalid;
                mem_rready  = ifu_rready;
            end
            LSU_RD: begin
                mem_araddr  = lsu_araddr;
                mem_arlen   = lsu_arlen;
                mem_arsize  = lsu_arsize;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
                lsu_rdata   = mem_rdata;
                lsu_rresp   = mem_rresp;
                lsu_rlast   = mem_rlast;
                lsu_rvalid  = mem_rvalid;
                mem_rready  = lsu_rready;
            end
            LSU_WR: begin
                // AW and W are independent: their handshakes may complete
                // in either order or in the same cycle.
                mem_awaddr  = lsu_awaddr;
                mem_awlen   = lsu_awlen;
                mem_awsize  = lsu_awsize;
                mem_awvalid = lsu_awvalid;
                lsu_awready = mem_awready;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wlast   = lsu_wlast;
                mem_wvalid  = lsu_wvalid;
                lsu_wready  = mem_wready;
                lsu_bresp   = mem_bresp;
                lsu_bvalid  = mem_bvalid;
                mem_bready  = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Directed testbench for ysyx_24100006_axi_arbiter. The bench plays both
// masters and the slave; inputs change 1 ns after the rising edge and
// outputs are compared 1 ns later, well away from the next edge.

module tb_ysyx_24100006_axi_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk;
    logic                reset;

    logic [ADDR_W-1:0]   ifu_araddr;
    logic [7:0]          ifu_arlen;
    logic [2:0]          ifu_arsize;
    logic                ifu_arvalid;
    logic                ifu_arready;
    logic [DATA_W-1:0]   ifu_rdata;
    logic [1:0]          ifu_rresp;
    logic                ifu_rlast;
    logic                ifu_rvalid;
    logic                ifu_rready;

    logic [ADDR_W-1:0]   lsu_araddr;
    logic [7:0]          lsu_arlen;
    logic [2:0]          lsu_arsize;
    logic                lsu_arvalid;
    logic                lsu_arready;
    logic [DATA_W-1:0]   lsu_rdata;
    logic [1:0]          lsu_rresp;
    logic                lsu_rlast;
    logic                lsu_rvalid;
    logic                lsu_rready;
    logic [ADDR_W-1:0]   lsu_awaddr;
    logic [7:0]          lsu_awlen;
    logic [2:0]          lsu_awsize;
    logic                lsu_awvalid;
    logic                lsu_awready;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wstrb;
    logic                lsu_wlast;
    logic                lsu_wvalid;
    logic                lsu_wready;
    logic [1:0]          lsu_bresp;
    logic                lsu_bvalid;
    logic                lsu_bready;

    logic [ADDR_W-1:0]   mem_araddr;
    logic [7:0]          mem_arlen;
    logic [2:0]          mem_arsize;
    logic                mem_arvalid;
    logic                mem_arready;
    logic [DATA_W-1:0]   mem_rdata;
    logic [1:0]          mem_rresp;
    logic                mem_rlast;
    logic                mem_rvalid;
    logic                mem_rready;
    logic [ADDR_W-1:0]   mem_awaddr;
    logic [7:0]          mem_awlen;
    logic [2:0]          mem_awsize;
    logic                mem_awvalid;
    logic                mem_awready;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_wlast;
    logic                mem_wvalid;
    logic                mem_wready;
    logic [1:0]          mem_bresp;
    logic                mem_bvalid;
    logic                mem_bready;

    int n_vec;
    int n_err;

    ysyx_24100006_axi_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ifu_araddr  (ifu_araddr),
        .ifu_arlen   (ifu_arlen),
        .ifu_arsize  (ifu_arsize),
        .ifu_arvalid (ifu_arvalid),
        .ifu_arready (ifu_arready),
        .ifu_rdata   (ifu_rdata),
        .ifu_rresp   (ifu_rresp),
        .ifu_rlast   (ifu_rlast),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rready  (ifu_rready),
        .lsu_araddr  (lsu_araddr),
        .lsu_arlen   (lsu_arlen),
        .lsu_arsize  (lsu_arsize),
        .lsu_arvalid (lsu_arvalid),
        .lsu_arready (lsu_arready),
        .lsu_rdata   (lsu_rdata),
        .lsu_rresp   (lsu_rresp),
        .lsu_rlast   (lsu_rlast),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_rready  (lsu_rready),
        .lsu_awaddr  (lsu_awaddr),
        .lsu_awlen   (lsu_awlen),
        .lsu_awsize  (lsu_awsize),
        .lsu_awvalid (lsu_awvalid),
        .lsu_awready (lsu_awready),
        .lsu_wdata   (lsu_wdata),
        .lsu_wstrb   (lsu_wstrb),
        .lsu_wlast   (lsu_wlast),
        .lsu_wvalid  (lsu_wvalid),
        .lsu_wready  (lsu_wready),
        .lsu_bresp   (lsu_bresp),
        .lsu_bvalid  (lsu_bvalid),
        .lsu_bready  (lsu_bready),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_arsize  (mem_arsize),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rlast   (mem_rlast),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .mem_awaddr  (mem_awaddr),
        .mem_awlen   (mem_awlen),
        .mem_awsize  (mem_awsize),
        .mem_awvalid (mem_awvalid),
        .mem_awready (mem_awready),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_wlast   (mem_wlast),
        .mem_wvalid  (mem_wvalid),
        .mem_wready  (mem_wready),
        .mem_bresp   (mem_bresp),
        .mem_bvalid  (mem_bvalid),
        .mem_bready  (mem_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve a single-beat read for the master that currently holds the
    // grant. Entered just after the granting edge, leaves in IDLE.
    task automatic serve_read(input bit is_lsu, input logic [31:0] addr, input logic [31:0] data);
        check("rd_ar_addr", mem_araddr, addr);
        check("rd_ar_valid", mem_arvalid, 1);
        mem_arready = 1'b1;
        #1;
        check(is_lsu ? "lsu_arready" : "ifu_arready", is_lsu ? lsu_arready : ifu_arready, 1);
        check("loser_arready", is_lsu ? ifu_arready : lsu_arready, 0);
        tick();
        if (is_lsu) lsu_arvalid = 1'b0;
        else        ifu_arvalid = 1'b0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = data;
        mem_rresp   = 2'b00;
        mem_rlast   = 1'b1;
        #1;
        check("win_rvalid", is_lsu ? lsu_rvalid : ifu_rvalid, 1);
        check("win_rdata", is_lsu ? lsu_rdata : ifu_rdata, data);
        check("lose_rvalid", is_lsu ? ifu_rvalid : lsu_rvalid, 0);
        check("mem_rready", mem_rready, 1);
        tick();
        // Back in IDLE: the still-high slave rvalid must be blocked.
        check("idle_rvalid", is_lsu ? lsu_rvalid : ifu_rvalid, 0);
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
    endtask

    // LSU single-beat write, W accepted one cycle before AW.
    task automatic lsu_write(input logic [1:0] bresp);
        lsu_awvalid = 1'b1;
        lsu_awaddr  = 32'h8000_1004;
        lsu_awlen   = 8'd0;
        lsu_awsize  = 3'd2;
        lsu_wvalid  = 1'b1;
        lsu_wdata   = 32'hDEAD_BEEF;
        lsu_wstrb   = 4'b0100;
        lsu_wlast   = 1'b1;
        #1;
        check("wr_idle_awvalid", mem_awvalid, 0);
        tick();
        check("wr_awvalid", mem_awvalid, 1);
        check("wr_awaddr", mem_awaddr, 32'h8000_1004);
        check("wr_wvalid", mem_wvalid, 1);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_wstrb", mem_wstrb, 4'b0100);
        check("wr_wlast", mem_wlast, 1);
        check("wr_arvalid", mem_arvalid, 0);
        mem_wready = 1'b1;
        #1;
        check("wr_wready", lsu_wready, 1);
        check("wr_awready_early", lsu_awready, 0);
        tick();
        lsu_wvalid  = 1'b0;
        mem_wready  = 1'b0;
        mem_awready = 1'b1;
        #1;
        check("wr_awready", lsu_awready, 1);
        check("wr_wvalid_done", mem_wvalid, 0);
        tick();
        lsu_awvalid = 1'b0;
        mem_awready = 1'b0;
        mem_bvalid  = 1'b1;
        mem_bresp   = bresp;
        #1;
        check("wr_bvalid", lsu_bvalid, 1);
        check("wr_bresp", lsu_bresp, bresp);
        check("wr_bready", mem_bready, 1);
        check("wr_ifu_rvalid", ifu_rvalid, 0);
        tick();
        check("wr_idle_bvalid", lsu_bvalid, 0);
        mem_bvalid = 1'b0;
        mem_bresp  = 2'b00;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        reset       = 1'b0;
        ifu_araddr  = '0; ifu_arlen = '0; ifu_arsize = '0; ifu_arvalid = 1'b0;
        ifu_rready  = 1'b1;
        lsu_araddr  = '0; lsu_arlen = '0; lsu_arsize = '0; lsu_arvalid = 1'b0;
        lsu_rready  = 1'b1;
        lsu_awaddr  = '0; lsu_awlen = '0; lsu_awsize = '0; lsu_awvalid = 1'b0;
        lsu_wdata   = '0; lsu_wstrb = '0; lsu_wlast = 1'b0; lsu_wvalid = 1'b0;
        lsu_bready  = 1'b1;
        mem_arready = 1'b0;
        mem_rdata   = 32'h1234_5678; mem_rresp = 2'b00; mem_rlast = 1'b1;
        mem_rvalid  = 1'b1;
        mem_awready = 1'b0; mem_wready = 1'b0;
        mem_bresp   = 2'b00; mem_bvalid = 1'b1;

        // Reset state: slave valids high must not reach either master.
        tick();
        check("rst_ifu_rvalid", ifu_rvalid, 0);
        check("rst_lsu_rvalid", lsu_rvalid, 0);
        check("rst_lsu_bvalid", lsu_bvalid, 0);
        check("rst_ifu_rdata", ifu_rdata, 0);
        check("rst_mem_rready", mem_rready, 0);
        check("rst_mem_bready", mem_bready, 0);
        mem_rvalid = 1'b0;
        mem_bvalid = 1'b0;
        mem_rlast  = 1'b0;
        mem_rdata  = '0;
        tick();

        // 1. IFU alone, slave AR ready after 2 cycles.
        reset       = 1'b1;
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0000;
        ifu_arlen   = 8'd0;
        ifu_arsize  = 3'd2;
        #1;
        check("t1_idle_arvalid", mem_arvalid, 0);
        check("t1_idle_arready", ifu_arready, 0);
        tick();
        check("t1_arvalid", mem_arvalid, 1);
        check("t1_arlen", mem_arlen, 0);
        check("t1_arsize", mem_arsize, 2);
        check("t1_lsu_arready", lsu_arready, 0);
        tick();
        check("t1_wait_arready", ifu_arready, 0);
        serve_read(1'b0, 32'h8000_0000, 32'h0000_0413);

        // 2. Simultaneous IFU and LSU requests, then a second tie.
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0000;
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1000;
        lsu_arlen   = 8'd0;
        lsu_arsize  = 3'd2;
        tick();
        serve_read(1'b1, 32'h8000_1000, 32'h1111_1111);
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1008;
        #1;
        check("t2_idle_gap", mem_arvalid, 0);
        tick();
`ifdef YSYX_24100006_ARB_RR_EN
        serve_read(1'b0, 32'h8000_0000, 32'h3333_3333);
        tick();
        serve_read(1'b1, 32'h8000_1008, 32'h2222_2222);
`else
        serve_read(1'b1, 32'h8000_1008, 32'h2222_2222);
        tick();
        serve_read(1'b0, 32'h8000_0000, 32'h3333_3333);
`endif

        // 3. LSU writes, OKAY then SLVERR passed through.
        lsu_write(2'b00);
        lsu_write(2'b10);

        // 4. IFU 4-beat burst with an LSU request arriving after beat 1.
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0100;
        ifu_arlen   = 8'd3;
        tick();
        check("t4_arlen", mem_arlen, 3);
        mem_arready = 1'b1;
        #1;
        check("t4_arready", ifu_arready, 1);
        tick();
        ifu_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hA0 + i;
            mem_rlast  = (i == 3);
            #1;
            check("t4_beat_valid", ifu_rvalid, 1);
            check("t4_beat_data", ifu_rdata, 32'hA0 + i);
            check("t4_beat_last", ifu_rlast, (i == 3));
            check("t4_lsu_arready", lsu_arready, 0);
            check("t4_lsu_rvalid", lsu_rvalid, 0);
            tick();
            if (i == 0) begin
                lsu_arvalid = 1'b1;
                lsu_araddr  = 32'h8000_2000;
                lsu_arlen   = 8'd0;
            end
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        #1;
        check("t4_idle_arready", lsu_arready, 0);
        check("t4_idle_arvalid", mem_arvalid, 0);
        tick();
        check("t4_lsu_addr", mem_araddr, 32'h8000_2000);
        check("t4_lsu_arready_gnt", lsu_arready, 1);
        tick();
        lsu_arvalid = 1'b0;
        mem_arready = 1'b0;

        // 5. Reset in LSU_RD after the AR handshake.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        mem_rlast  = 1'b0;
        #1;
        check("t5_lsu_rvalid", lsu_rvalid, 1);
        check("t5_mem_rready", mem_rready, 1);
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0200;
        ifu_arlen   = 8'd0;
        reset       = 1'b0;
        #1;
        check("t5_rst_rready", mem_rready, 0);
        check("t5_rst_lsu_rvalid", lsu_rvalid, 0);
        check("t5_rst_lsu_rdata", lsu_rdata, 0);
        check("t5_rst_arvalid", mem_arvalid, 0);
        check("t5_rst_awvalid", mem_awvalid, 0);
        check("t5_rst_wvalid", mem_wvalid, 0);
        check("t5_rst_bready", mem_bready, 0);
        tick();
        reset      = 1'b1;
        mem_rvalid = 1'b0;
        #1;
        check("t5_rel_arvalid", mem_arvalid, 0);
        tick();
        check("t5_ifu_gnt", mem_arvalid, 1);
        check("t5_ifu_addr", mem_araddr, 32'h8000_0200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
